// File: rtl/disp_seq_ctrl.sv
// Message buffer and static/marquee sequencer for an 8-digit 7-segment scanner; define DISP_SEQ_BLINK_EN to blink static messages.
// Latency: a state or scroll-position change reaches x*_out one clock later; all outputs registered.
// Backpressure: wr_ready is high only in IDLE with buffer space; writes are refused while displaying or full.
module disp_seq_ctrl #(
    parameter int         MSG_DEPTH  = 16,
    parameter int         TICK_DIV   = 25000000,
    parameter logic [5:0] BLANK_CODE = 6'd63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic [5:0] wr_char,
    output logic       wr_ready,
    input  logic       clear,
    input  logic       start,
    input  logic       stop,
    input  logic       repeat_en,
    output logic       busy,
    output logic       wrap,
    output logic [5:0] len,
    output logic [5:0] x7_out,
    output logic [5:0] x6_out,
    output logic [5:0] x5_out,
    output logic [5:0] x4_out,
    output logic [5:0] x3_out,
    output logic [5:0] x2_out,
    output logic [5:0] x1_out,
    output logic [5:0] x0_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STATIC = 2'd1;
    localparam logic [1:0] S_SCROLL = 2'd2;

    localparam int          AW        = $clog2(MSG_DEPTH);
    localparam int          TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [5:0]  DEPTH6    = 6'(MSG_DEPTH);

    logic [5:0]    buf_q [MSG_DEPTH];
    logic [1:0]    state_q, state_d;
    logic [5:0]    len_q, len_d;
    logic [5:0]    pos_q, pos_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          rep_q, rep_d;
    logic          show_q, show_d;
    logic          wrap_q, wrap_d;
    logic          busy_q;
    logic          wr_ready_q;
    logic          wr_en;
    logic          go;
    logic [5:0]    stream_len;
    logic [5:0]    disp_q [8];
    logic [5:0]    disp_d [8];

    assign stream_len = len_q + 6'd8;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pos_d   = pos_q;
        tick_d  = tick_q;
        rep_d   = rep_q;
        show_d  = show_q;
        wrap_d  = 1'b0;
        wr_en   = 1'b0;
        go      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    len_d = 6'd0;
                end else if (wr_valid && wr_ready_q) begin
                    wr_en = 1'b1;
                    len_d = len_q + 6'd1;
                end
                go = start && (len_d != 6'd0);
            end
            S_STATIC: begin
`ifdef DISP_SEQ_BLINK_EN
                if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    show_d = ~show_q;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
`endif
                if (stop)
                    state_d = S_IDLE;
                else
                    go = start;
            end
            S_SCROLL: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    go = 1'b1;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (pos_q == stream_len - 6'd1) begin
                        pos_d  = 6'd0;
                        wrap_d = 1'b1;
                        if (!rep_q)
                            state_d = S_IDLE;
                    end else begin
                        pos_d = pos_q + 6'd1;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Entry conditions shared by start-from-IDLE and restart-while-busy.
        if (go) begin
            pos_d  = 6'd0;
            tick_d = '0;
            show_d = 1'b1;
            if (len_d > 6'd8) begin
                state_d = S_SCROLL;
                rep_d   = repeat_en;
            end else begin
                state_d = S_STATIC;
            end
        end
    end

    function automatic logic [5:0] digit_code(input logic [5:0] k);
        logic [5:0] idx;
        logic [5:0] bi;
        digit_code = BLANK_CODE;
        idx = pos_q + k;
        if (idx >= stream_len)
            idx = idx - stream_len;
        bi = idx - 6'd8;
        if (state_q == S_STATIC) begin
            if (show_q && (k < len_q))
                digit_code = buf_q[k[AW-1:0]];
        end else if (state_q == S_SCROLL) begin
            if (idx >= 6'd8)
                digit_code = buf_q[bi[AW-1:0]];
        end
    endfunction

    always_comb begin
        for (int k = 0; k < 8; k++)
            disp_d[k] = digit_code(6'(k));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= 6'd0;
            pos_q      <= 6'd0;
            tick_q     <= '0;
            rep_q      <= 1'b0;
            show_q     <= 1'b1;
            wrap_q     <= 1'b0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b0;
            for (int k = 0; k < 8; k++)
                disp_q[k] <= BLANK_CODE;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            pos_q      <= pos_d;
            tick_q     <= tick_d;
            rep_q      <= rep_d;
            show_q     <= show_d;
            wrap_q     <= wrap_d;
            busy_q     <= (state_d != S_IDLE);
            wr_ready_q <= (state_d == S_IDLE) && (len_d < DEPTH6);
            for (int k = 0; k < 8; k++)
                disp_q[k] <= disp_d[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en)
            buf_q[len_q[AW-1:0]] <= wr_char;
    end

    assign wr_ready = wr_ready_q;
    assign busy     = busy_q;
    assign wrap     = wrap_q;
    assign len      = len_q;
    assign x7_out   = disp_q[0];
    assign x6_out   = disp_q[1];
    assign x5_out   = disp_q[2];
    assign x4_out   = disp_q[3];
    assign x3_out   = disp_q[4];
    assign x2_out   = disp_q[5];
    assign x1_out   = disp_q[6];
    assign x0_out   = disp_q[7];

endmodule

// File: doc/disp_seq_ctrl.md
Name: disp_seq_ctrl

Overview:
- Sequencer feeding the 8-digit 7-segment scanner's eight 6-bit character-code inputs.
- Buffers a message of up to MSG_DEPTH character codes, written one code per handshake.
- Messages of 8 characters or fewer are shown static and left-aligned.
- Longer messages scroll as a right-to-left marquee at a rate set by a clock-cycle divider.
- Character codes: 0-35 are 0-9 and a-z; 63 is blank.

Parameters:
- MSG_DEPTH, 16, buffer entries (9..32).
- TICK_DIV, 25000000, clk cycles per scroll step; the bench uses 4.
- BLANK_CODE, 6'd63, code driven for an empty digit.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_char  in  6  character code to write.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- clear  in  1  pulse; empties the buffer (len=0).
- start  in  1  pulse; begin display.
- stop  in  1  pulse; return to IDLE.
- repeat_en  in  1  sampled at start; 1 = scroll endlessly, 0 = one pass.
- busy  out  1  high in STATIC or SCROLL.
- wrap  out  1  one-cycle pulse when the scroll position wraps.
- len  out  6  current message length.
- x7_out..x0_out  out  6 each  digit codes; x7_out is the leftmost digit, x0_out the rightmost.

Behaviour:
- Reset, registered in the clk domain:
  - All x*_out = BLANK_CODE; wr_ready=0, busy=0, wrap=0, len=0.
  - State = IDLE; pos=0; tick counter=0.
  - Buffer contents are don't-care.
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and rst; rst takes priority over every input.
- Outputs are registered. A state or pos change is visible on x*_out one cycle later.
- States: IDLE, STATIC, SCROLL.
- IDLE:
  - x*_out = BLANK_CODE.
  - wr_ready = (len < MSG_DEPTH).
  - An accepted write stores wr_char at buf[len] and increments len.
  - clear sets len=0. clear and a write in the same cycle: clear wins and the write is dropped.
  - start with len==0: ignored.
  - start with 1<=len<=8: go to STATIC.
  - start with len>8: go to SCROLL with pos=0 and tick=0; repeat_en is latched.
- STATIC:
  - Digit k (k=0 leftmost, i.e. x7_out) shows buf[k] for k<len, else BLANK_CODE.
  - wr_ready=0; clear is ignored.
- SCROLL:
  - Stream length L = len+8. s[j] = BLANK_CODE for j<8, else buf[j-8].
  - Digit k shows s[(pos+k) mod L]; pos=0 is an all-blank display.
  - Tick counter counts 0..TICK_DIV-1. On terminal count, pos advances by 1.
  - pos wraps from L-1 to 0 and pulses wrap in that same cycle.
  - On the wrap step with repeat_en latched 0: go to IDLE instead; wrap still pulses and the display blanks.
  - wr_ready=0; clear is ignored.
- stop in STATIC or SCROLL: go to IDLE next cycle; the buffer and len are kept.
- start while busy: restart from the entry conditions for the current len (pos=0, tick=0).
- start and stop in the same cycle: stop wins.
- Full buffer: wr_ready=0 at len==MSG_DEPTH; wr_valid is ignored with no overflow and no wrap of the write pointer.
- Reset asserted mid-scroll: next cycle all outputs are at their reset values and len=0.

Optional Feature:
- Macro: DISP_SEQ_BLINK_EN.
- When defined: in STATIC, the display alternates between the message and all-BLANK_CODE every TICK_DIV cycles.
  - Message phase first after entering STATIC; the tick counter is reset on entry.
- When undefined: STATIC is steady, and the tick counter is idle outside SCROLL.

Test Plan:
- Reset, then write codes 17,14,21,21,24 ("hello"), then start → from two cycles after start: x7..x0 = 17,14,21,21,24,63,63,63; busy=1; wrap never pulses; len=5.
- Write 10 codes 0..9 with repeat_en=0, start, TICK_DIV=4 →
  - pos 0: all 63.
  - After 4 cycles: x0_out=0.
  - At pos=8: x7..x0 = 0..7.
  - After 18 steps (L=18): wrap pulses once, busy falls, outputs return to 63.
- Same message with repeat_en=1 → wrap pulses every 72 cycles; the display sequence repeats identically; no return to IDLE until stop, then all 63 next cycle.
- Write 17 codes with MSG_DEPTH=16 → wr_ready falls after the 16th accept; the 17th is not stored; len=16.
- clear asserted together with wr_valid in IDLE → len=0; start is then ignored and busy stays 0.
- start and stop asserted together during SCROLL → IDLE, busy=0. Then assert rst mid-scroll → all x*_out=63 and len=0 on the next cycle.
